dmem_responder: RTL and testbench

Data-memory responder for the single-cycle RV32I core: serves the datapath's load/store port, with the ALU result as address, rs2 as store data and the load result returned to writeback. It holds a byte-lane word RAM plus an optional memory-mapped I/O window (LEDs, switches, free-running cycle counter, error status). Stores commit on the clock edge. Loads are combinational so the core still completes each instruction in one cycle.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_ram.sv | 25 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: load/store width codes,
// I/O window register offsets and the byte-enable helper.
// Optional I/O window is controlled by the DMEM_MMIO_EN macro in dmem_responder.
package dmem_pkg;

  // func3 width/sign codes shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte offsets of the I/O registers inside the 16-byte window
  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_SW     = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // Lane mask for a store of the given width at the given byte offset
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-lane word RAM, 2^ADDR_W x 32, one shared address for read and write.
// Latency: read is combinational, write commits on the rising clock edge.
// No backpressure: every enabled lane is written the cycle it is requested.
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Write only the enabled byte lanes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle RV32I core: RAM + optional I/O window (DMEM_MMIO_EN).
// Latency: loads are combinational (0 cycles), stores and register updates commit on the next edge.
// No backpressure: every access completes in its own cycle; bad accesses are dropped and flagged.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] MMIO_BASE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [15:0] sw_in,
  output logic [15:0] led,
  output logic        access_err
);

  logic        ram_hit;
  logic        f3_ok;
  logic        misalign;
  logic        narrow_io;
  logic        err_now;
  logic        store_en;
  logic        status_clr;
  logic [3:0]  ram_we;
  logic [31:0] lane_dat;
  logic [31:0] ram_rdata;
  logic [31:0] src_word;
  logic [31:0] shifted;
  logic [31:0] ext_word;

  // RAM occupies byte addresses 0 .. 4*2^ADDR_W-1
  assign ram_hit = (addr[31:ADDR_W+2] == '0);

  // Width legality depends on direction: stores have no unsigned variants
  assign f3_ok = mem_we ? (func3 inside {F3_B, F3_H, F3_W})
                        : (func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                    ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

`ifdef DMEM_MMIO_EN
  logic        io_hit;
  logic        io_we;
  logic [15:0] led_q;
  logic [31:0] cycle_q;
  logic [31:0] io_rdata;

  assign io_hit    = (addr[31:4] == MMIO_BASE[31:4]);
  assign narrow_io = io_hit && (func3 != F3_W);
`else
  assign narrow_io = 1'b0;
`endif

  // Simultaneous load+store is treated as a bad access, like the others
  assign err_now  = (mem_re || mem_we) &&
                    ((mem_re && mem_we) || !f3_ok || misalign || narrow_io);
  // A store during reset must not reach the RAM
  assign store_en = rst_n && mem_we && !err_now;

  // Replicate store data across lanes so the byte enable alone picks the target
  always_comb begin
    lane_dat = wr_data;
    case (func3[1:0])
      2'b00:   lane_dat = {4{wr_data[7:0]}};
      2'b01:   lane_dat = {2{wr_data[15:0]}};
      default: lane_dat = wr_data;
    endcase
  end

  assign ram_we = (store_en && ram_hit) ? byte_en(func3, addr[1:0]) : 4'b0000;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr[ADDR_W+1:2]),
    .wdata (lane_dat),
    .rdata (ram_rdata)
  );

`ifdef DMEM_MMIO_EN
  assign io_we      = store_en && io_hit;
  assign status_clr = io_we && (addr[3:0] == OFF_STATUS) && wr_data[0];
  assign led        = led_q;

  // LED register and free-running cycle counter; a CYCLE write overrides the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      cycle_q <= '0;
    end else begin
      if (io_we && (addr[3:0] == OFF_LED)) led_q <= wr_data[15:0];
      if (io_we && (addr[3:0] == OFF_CYCLE)) cycle_q <= wr_data;
      else                                  cycle_q <= cycle_q + 32'd1;
    end
  end

  // I/O read mux; word alignment is already enforced so only the offset matters
  always_comb begin
    io_rdata = '0;
    case (addr[3:0])
      OFF_LED:    io_rdata = {16'b0, led_q};
      OFF_SW:     io_rdata = {16'b0, sw_in};
      OFF_CYCLE:  io_rdata = cycle_q;
      OFF_STATUS: io_rdata = {31'b0, access_err};
      default:    io_rdata = '0;
    endcase
  end

  assign src_word = ram_hit ? ram_rdata : (io_hit ? io_rdata : '0);
`else
  logic unused_sw;
  assign unused_sw  = ^sw_in;
  assign status_clr = 1'b0;
  assign led        = '0;
  assign src_word   = ram_hit ? ram_rdata : '0;
`endif

  assign shifted = src_word >> {addr[1:0], 3'b000};

  // Sign- or zero-extend the addressed lane
  always_comb begin
    ext_word = '0;
    case (func3)
      F3_B:    ext_word = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ext_word = {24'b0, shifted[7:0]};
      F3_H:    ext_word = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ext_word = {16'b0, shifted[15:0]};
      F3_W:    ext_word = src_word;
      default: ext_word = '0;
    endcase
  end

  assign rd_data = (rst_n && mem_re && !err_now) ? ext_word : '0;

  // Sticky error flag; a fresh error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) access_err <= 1'b0;
    else        access_err <= err_now || (access_err && !status_clr);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model, directed steps, then random traffic.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          ADDR_W    = 8;
  localparam int          RAM_BYTES = 4 << ADDR_W;
  localparam logic [31:0] BASE      = 32'h0000_8000;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [15:0] sw_in;
  logic [15:0] led;
  logic        access_err;

  dmem_responder #(.ADDR_W(ADDR_W), .MMIO_BASE(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .func3      (func3),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .sw_in      (sw_in),
    .led        (led),
    .access_err (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mb [RAM_BYTES];
  logic [15:0] m_led;
  logic [31:0] m_cycle;
  logic        m_err;
  int          passed;
  int          failed;
  int          total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit in_io(input logic [31:0] a);
    return MMIO_ON && (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  // Expected load value and error verdict for one access, from the rules directly
  task automatic model_eval(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a,
                            output logic [31:0] rd, output bit err);
    int   size;
    bit   legal;
    logic [31:0] v;
    size  = acc_size(f3);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = (re || we) && ((re && we) || !legal || ((a % size) != 0) || (in_io(a) && size != 4));
    rd    = '0;
    if (re && !err) begin
      v = '0;
      if (a < RAM_BYTES) begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = mb[int'(a) + i];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      end else if (in_io(a)) begin
        case (a - BASE)
          32'd0:   v = {16'b0, m_led};
          32'd4:   v = {16'b0, sw_in};
          32'd8:   v = m_cycle;
          32'd12:  v = {31'b0, m_err};
          default: v = '0;
        endcase
      end
      rd = v;
    end
  endtask

  // One core cycle: drive, check combinational load, clock, update model, check state
  task automatic do_op(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    bit          err;
    bit          clr;
    bit          cyc_wr;
    mem_re  = re;
    mem_we  = we;
    func3   = f3;
    addr    = a;
    wr_data = wd;
    #1;
    model_eval(re, we, f3, a, exp_rd, err);
    check({tag, ":rd"}, rd_data, exp_rd);
    @(posedge clk);
    clr    = 1'b0;
    cyc_wr = 1'b0;
    if (we && !err) begin
      if (a < RAM_BYTES) begin
        for (int i = 0; i < acc_size(f3); i++) mb[int'(a) + i] = wd[8*i +: 8];
      end else if (in_io(a)) begin
        if (a == BASE)          m_led = wd[15:0];
        if (a == BASE + 32'd8)  begin m_cycle = wd; cyc_wr = 1'b1; end
        if (a == BASE + 32'd12) clr = wd[0];
      end
    end
    if (!cyc_wr) m_cycle = m_cycle + 32'd1;
    m_err = err || (m_err && !clr);
    #1;
    mem_re = 1'b0;
    mem_we = 1'b0;
    check({tag, ":err"}, {31'b0, access_err}, {31'b0, m_err});
    check({tag, ":led"}, {16'b0, led}, {16'b0, m_led});
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    mem_re = 0; mem_we = 0; func3 = F3_W; addr = 0; wr_data = 0; sw_in = 16'h0;
    m_led = 0; m_cycle = 0; m_err = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_re = 1'b1;
    #1;
    check("reset_led", {16'b0, led}, 32'h0);
    check("reset_err", {31'b0, access_err}, 32'h0);
    check("reset_rd", rd_data, 32'h0);
    mem_re = 1'b0;
    rst_n = 1'b1;

    // Fill RAM with known random words
    for (int w = 0; w < (1 << ADDR_W); w++) do_op(0, 1, F3_W, 32'(w * 4), $urandom, "init");

    // Word round trip and simultaneous load+store
    do_op(0, 1, F3_W, 32'h10, 32'hDEADBEEF, "sw10");
    do_op(1, 0, F3_W, 32'h10, 32'h0, "lw10");
    check("lw10_lit", {mb[19], mb[18], mb[17], mb[16]}, 32'hDEADBEEF);
    do_op(1, 1, F3_W, 32'h10, 32'h11111111, "both");
    do_op(1, 0, F3_W, 32'h10, 32'h0, "lw10_kept");
    do_op(0, 1, F3_W, BASE + 32'hC, 32'h1, "clr0");

    // Byte and halfword lanes
    do_op(0, 1, F3_B, 32'h21, 32'h00000080, "sb21");
    do_op(1, 0, F3_B, 32'h21, 32'h0, "lb21");
    do_op(1, 0, F3_BU, 32'h21, 32'h0, "lbu21");
    do_op(0, 1, F3_H, 32'h22, 32'h00001234, "sh22");
    do_op(1, 0, F3_W, 32'h20, 32'h0, "lw20");
    do_op(1, 0, F3_HU, 32'h22, 32'h0, "lhu22");

    // Misalignment and sticky flag handling
    do_op(0, 1, F3_W, 32'h13, 32'hCAFEF00D, "sw13");
    do_op(1, 0, F3_W, 32'h10, 32'h0, "lw10_after_mis");
    do_op(0, 1, F3_W, BASE + 32'hC, 32'h1, "clr1");
    do_op(0, 1, F3_H, 32'h21, 32'h0, "sh21");
    do_op(1, 1, F3_W, BASE + 32'hC, 32'h1, "err_and_clr");
    do_op(0, 1, 3'b011, 32'h30, 32'h0, "bad_f3");
    do_op(0, 1, F3_W, BASE + 32'hC, 32'h1, "clr2");

    // I/O window
    sw_in = 16'h5A5A;
    do_op(0, 1, F3_W, BASE, 32'h0000ABCD, "led_wr");
    do_op(1, 0, F3_W, BASE + 32'h4, 32'h0, "sw_rd");
    do_op(0, 1, F3_H, BASE, 32'h00001111, "led_sh");
    do_op(0, 1, F3_W, BASE + 32'hC, 32'h1, "clr3");
    do_op(0, 1, F3_W, BASE + 32'h8, 32'hFFFFFFFE, "cyc_wr");
    do_op(1, 0, F3_W, BASE + 32'h8, 32'h0, "cyc_rd0");
    do_op(1, 0, F3_W, BASE + 32'h8, 32'h0, "cyc_rd1");
`ifdef DMEM_MMIO_EN
    mem_re = 1'b1; func3 = F3_W; addr = BASE + 32'h8;
    #1;
    check("cyc_wrap", rd_data, 32'h0);
    mem_re = 1'b0;
    check("led_lit", {16'b0, led}, 32'h0000ABCD);
`endif
    do_op(1, 0, F3_W, 32'h0001_0040, 32'h0, "unmapped_rd");
    do_op(0, 1, F3_W, 32'h0001_0040, 32'h0, "unmapped_wr");

    // Reset mid-run with a store pending
    mem_we = 1'b1; mem_re = 1'b0; func3 = F3_W; addr = 32'h10; wr_data = 32'h0BADF00D;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_err", {31'b0, access_err}, 32'h0);
    @(posedge clk);
    #1;
    mem_we = 1'b0; mem_re = 1'b1;
    #1;
    check("rst_rd", rd_data, 32'h0);
    mem_re = 1'b0;
    rst_n  = 1'b1;
    m_led = 0; m_cycle = 0; m_err = 0;
    do_op(1, 0, F3_W, BASE + 32'h8, 32'h0, "cyc_after_rst");
    do_op(1, 0, F3_W, 32'h10, 32'h0, "ram_after_rst");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int          kind;
      int          cat;
      bit          re;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [2:0]  legal_f3 [5];
      legal_f3[0] = F3_B; legal_f3[1] = F3_H; legal_f3[2] = F3_W;
      legal_f3[3] = F3_BU; legal_f3[4] = F3_HU;
      sw_in = 16'($urandom);
      kind  = $urandom_range(0, 9);
      re    = (kind <= 4) || (kind == 9);
      we    = (kind >= 5 && kind <= 8) || (kind == 9 && $urandom_range(0, 1) == 1);
      cat   = $urandom_range(0, 9);
      if (cat <= 6)      a = 32'($urandom_range(0, RAM_BYTES - 1));
      else if (cat <= 8) a = BASE + 32'($urandom_range(0, 15));
      else               a = $urandom | 32'h0001_0000;
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else                           f3 = we ? legal_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
      if ((f3[1:0] == 2'b10 || cat == 7 || cat == 8) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (f3[1:0] == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      do_op(re, we, f3, a, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
